// File: rtl/dump_ctrl_pkg.sv
// Shared definitions for the capture-RAM dump controller.
// Contents:
//   state_t       - controller FSM state encoding
//   EEP_SS_CODE   - slave select of the calibration EEPROM
//   SPI_RD_PREFIX - top bits of the EEPROM read command word
//   eep_rd_cmd()  - builds the 16-bit EEPROM read command for a channel/gain pair
package dump_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_OFF  = 4'd1,
        WT_OFF  = 4'd2,
        RD_GAIN = 4'd3,
        WT_GAIN = 4'd4,
        RAM_RD  = 4'd5,
        SEND    = 4'd6,
        WT_TX   = 4'd7,
        FIN     = 4'd8
    } state_t;

    localparam logic [2:0] EEP_SS_CODE   = 3'b100;
    localparam logic [1:0] SPI_RD_PREFIX = 2'b00;

    // EEPROM address layout: {channel, gain code, offset(0)/gain(1) select}.
    // The low byte is a don't-care filler clocked out while the EEPROM answers.
    function automatic logic [15:0] eep_rd_cmd(input logic [1:0] ch,
                                               input logic [2:0] gain,
                                               input logic       gain_sel);
        return {SPI_RD_PREFIX, ch, gain, gain_sel, 8'h00};
    endfunction

endpackage

// File: rtl/dump_addr_cnt.sv
// Capture-RAM read address and sample counter for one dump.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - start of dump: addr <= load_addr, sample count <= 0
//   load_addr  - first (oldest) sample address
//   inc        - advance to the next sample (address wraps DEPTH-1 -> 0)
//   addr       - current RAM read address
//   last       - current sample is the DEPTH-th (final) sample of the dump
module dump_addr_cnt #(
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   addr,
    output logic                       last
);

    localparam int            AW  = $clog2(DEPTH);
    localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_r;
    logic [AW-1:0] cnt_r;

    // Address and sample counter registers with explicit DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= {AW{1'b0}};
            cnt_r  <= {AW{1'b0}};
        end else if (load) begin
            addr_r <= load_addr;
            cnt_r  <= {AW{1'b0}};
        end else if (inc) begin
            addr_r <= (addr_r == TOP) ? {AW{1'b0}} : addr_r + ONE;
            cnt_r  <= (cnt_r == TOP) ? {AW{1'b0}} : cnt_r + ONE;
        end else begin
            addr_r <= addr_r;
            cnt_r  <= cnt_r;
        end
    end

    assign addr = addr_r;
    assign last = (cnt_r == TOP);

endmodule

// File: rtl/dump_ctrl.sv
// Dump controller: on a dump request, reads the offset and gain calibration
// bytes for the selected channel/AFE gain from the SPI EEPROM (strobing the
// correction registers as each byte arrives), then streams all DEPTH captured
// samples from the capture RAM, oldest first, handing each to the UART.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   dump, dump_ch                    - one-cycle dump request and channel (11 reserved)
//   ch1/ch2/ch3_AFEgain              - current AFE gain codes per channel
//   trig_addr                        - RAM address of the newest sample
//   SPI_done, EEP_data               - SPI completion and EEPROM read data
//   wrt_SPI, ss, SPI_data            - SPI start pulse, slave select, command word
//   flopOffset, flopGain             - correction register load strobes
//   ram_addr, ram_ch, ram_rd         - capture RAM read port
//   send_resp, resp_sent             - UART send pulse / byte-done handshake
//   busy, dump_done, dump_err        - status
module dump_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int         DEPTH  = 512,
    parameter logic [2:0] EEP_SS = EEP_SS_CODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dump,
    input  logic [1:0]                 dump_ch,
    input  logic [2:0]                 ch1_AFEgain,
    input  logic [2:0]                 ch2_AFEgain,
    input  logic [2:0]                 ch3_AFEgain,
    input  logic [$clog2(DEPTH)-1:0]   trig_addr,
    input  logic                       SPI_done,
    input  logic [7:0]                 EEP_data,
    output logic                       wrt_SPI,
    output logic [2:0]                 ss,
    output logic [15:0]                SPI_data,
    output logic                       flopOffset,
    output logic                       flopGain,
    output logic [$clog2(DEPTH)-1:0]   ram_addr,
    output logic [1:0]                 ram_ch,
    output logic                       ram_rd,
    output logic                       send_resp,
    input  logic                       resp_sent,
    output logic                       busy,
    output logic                       dump_done,
    output logic                       dump_err
);

    localparam int            AW  = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t      state_r;
    state_t      next_state_s;
    logic        load_s;
    logic        inc_s;
    logic        err_s;
    logic [2:0]  gain_sel_s;
    logic [1:0]  ch_s;
    logic [2:0]  gain_s;
    logic        last_s;

    logic [1:0]  ch_r;
    logic [2:0]  gain_r;
    logic        wrt_spi_r;
    logic [2:0]  ss_r;
    logic [15:0] spi_data_r;
    logic        ram_rd_r;
    logic        send_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        wt_off_r;
    logic        wt_gain_r;

    // EEP_data is consumed by the correction registers, not by this block.
    logic        unused_s;
    assign unused_s = ^EEP_data;

    dump_addr_cnt #(.DEPTH(DEPTH)) u_addr_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_addr (trig_addr + ONE),
        .inc       (inc_s),
        .addr      (ram_addr),
        .last      (last_s)
    );

    // Gain code of the channel named by the incoming request.
    always_comb begin
        gain_sel_s = 3'b000;
        case (dump_ch)
            2'b00:   gain_sel_s = ch1_AFEgain;
            2'b01:   gain_sel_s = ch2_AFEgain;
            2'b10:   gain_sel_s = ch3_AFEgain;
            default: gain_sel_s = 3'b000;
        endcase
    end

    // Channel/gain used to build the command: the request itself on the
    // loading cycle (latches not yet updated), the latched copy afterwards.
    always_comb begin
        ch_s   = ch_r;
        gain_s = gain_r;
        if (load_s) begin
            ch_s   = dump_ch;
            gain_s = gain_sel_s;
        end else begin
            ch_s   = ch_r;
            gain_s = gain_r;
        end
    end

    // Next-state logic and counter/error controls.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        inc_s        = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (dump) begin
                    if (dump_ch == 2'b11) begin
                        err_s = 1'b1;
                    end else begin
                        load_s       = 1'b1;
                        next_state_s = RD_OFF;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_OFF:  next_state_s = WT_OFF;
            WT_OFF: begin
                if (SPI_done) begin
                    next_state_s = RD_GAIN;
                end else begin
                    next_state_s = WT_OFF;
                end
            end
            RD_GAIN: next_state_s = WT_GAIN;
            WT_GAIN: begin
                if (SPI_done) begin
                    next_state_s = RAM_RD;
                end else begin
                    next_state_s = WT_GAIN;
                end
            end
            RAM_RD:  next_state_s = SEND;
            SEND:    next_state_s = WT_TX;
            WT_TX: begin
                if (resp_sent) begin
                    inc_s        = 1'b1;
                    next_state_s = last_s ? FIN : RAM_RD;
                end else begin
                    next_state_s = WT_TX;
                end
            end
            FIN:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state, so each
    // strobe is high exactly while the FSM sits in its owning state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ch_r       <= 2'b00;
            gain_r     <= 3'b000;
            wrt_spi_r  <= 1'b0;
            ss_r       <= 3'b000;
            spi_data_r <= 16'h0000;
            ram_rd_r   <= 1'b0;
            send_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            wt_off_r   <= 1'b0;
            wt_gain_r  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            ch_r      <= ch_s;
            gain_r    <= gain_s;
            wrt_spi_r <= (next_state_s == RD_OFF) || (next_state_s == RD_GAIN);
            ss_r      <= ((next_state_s == RD_OFF)  || (next_state_s == WT_OFF) ||
                          (next_state_s == RD_GAIN) || (next_state_s == WT_GAIN))
                         ? EEP_SS : 3'b000;
            // Command word loads on entry to a read state and holds through its wait.
            if (next_state_s == RD_OFF) begin
                spi_data_r <= eep_rd_cmd(ch_s, gain_s, 1'b0);
            end else if (next_state_s == RD_GAIN) begin
                spi_data_r <= eep_rd_cmd(ch_s, gain_s, 1'b1);
            end else if ((next_state_s == WT_OFF) || (next_state_s == WT_GAIN)) begin
                spi_data_r <= spi_data_r;
            end else begin
                spi_data_r <= 16'h0000;
            end
            ram_rd_r  <= (next_state_s == RAM_RD);
            send_r    <= (next_state_s == SEND);
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (next_state_s == FIN);
            err_r     <= err_s;
            wt_off_r  <= (next_state_s == WT_OFF);
            wt_gain_r <= (next_state_s == WT_GAIN);
        end
    end

    assign wrt_SPI    = wrt_spi_r;
    assign ss         = ss_r;
    assign SPI_data   = spi_data_r;
    // Correction registers capture EEP_data in the very cycle SPI_done reports it.
    assign flopOffset = wt_off_r & SPI_done;
    assign flopGain   = wt_gain_r & SPI_done;
    assign ram_ch     = ch_r;
    assign ram_rd     = ram_rd_r;
    assign send_resp  = send_r;
    assign busy       = busy_r;
    assign dump_done  = done_r;
    assign dump_err   = err_r;

endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning samples per channel capture RAM (power of 2).
REQ-002 SHALL have parameter EEP_SS, default 3'b100, meaning the slave select for the calibration EEPROM.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: dump  in  1  one-cycle dump request; dump_ch  in  2  channel (00/01/10; 11 reserved).
REQ-006 SHALL have ports: ch1_AFEgain, ch2_AFEgain, ch3_AFEgain  in  3 each  current AFE gain codes.
REQ-007 SHALL have ports: trig_addr  in  log2(DEPTH)  RAM address of the newest captured sample.
REQ-008 SHALL have ports: SPI_done  in  1  SPI transaction complete; EEP_data  in  8  EEPROM read data, valid with SPI_done.
REQ-009 SHALL have ports: wrt_SPI  out  1  SPI start pulse; ss  out  3  slave select; SPI_data  out  16  SPI word.
REQ-010 SHALL have ports: flopOffset, flopGain  out  1 each  one-cycle load strobes for the correction registers.
REQ-011 SHALL have ports: ram_addr  out  log2(DEPTH)  RAM read address; ram_ch  out  2  RAM select; ram_rd  out  1  read strobe.
REQ-012 SHALL have ports: send_resp  out  1  UART send pulse (corrected sample valid); resp_sent  in  1  UART byte done.
REQ-013 SHALL have ports: busy  out  1  dump in progress; dump_done  out  1  one-cycle pulse at completion; dump_err  out  1  one-cycle pulse for reserved channel.

Function
REQ-014 SHALL use states IDLE, RD_OFF, WT_OFF, RD_GAIN, WT_GAIN, RAM_RD, SEND, WT_TX, FIN.
REQ-015 IDLE: dump with dump_ch!=11 SHALL latch dump_ch and the selected channel's AFE gain code and set ram_addr=trig_addr+1 (mod DEPTH), count=0, next RD_OFF.
REQ-016 IDLE: dump with dump_ch==11 SHALL pulse dump_err next cycle, issue no SPI, RAM or UART activity, stay IDLE.
REQ-017 RD_OFF: one-cycle wrt_SPI, ss=EEP_SS, SPI_data={2'b00, ch[1:0], gain[2:0], 1'b0, 8'h00}; next WT_OFF.
REQ-018 WT_OFF: on SPI_done pulse flopOffset same cycle, next RD_GAIN; RD_GAIN identical to RD_OFF with address LSB=1; WT_GAIN pulses flopGain on SPI_done.
REQ-019 ss and SPI_data SHALL hold stable from the wrt_SPI cycle until SPI_done.
REQ-020 RAM_RD: one-cycle ram_rd with ram_ch/ram_addr; next SEND (RAM read latency one cycle).
REQ-021 SEND: one-cycle send_resp, ram_addr held; next WT_TX.
REQ-022 WT_TX: on resp_sent increment ram_addr modulo DEPTH (DEPTH-1 wraps to 0) and count; if count was DEPTH-1 next FIN, else RAM_RD.
REQ-023 Exactly DEPTH samples SHALL be sent, oldest (trig_addr+1) first, newest (trig_addr) last.
REQ-024 FIN: one-cycle dump_done, next IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 dump asserted while busy SHALL be ignored; the in-progress dump is unaffected.
REQ-027 SPI_done/resp_sent outside their wait states SHALL be ignored.
REQ-028 All strobes (wrt_SPI, flopOffset, flopGain, ram_rd, send_resp, dump_done, dump_err) SHALL be registered-state decoded, one cycle wide, never simultaneous except flopOffset/flopGain with nothing.

Reset
REQ-029 rst SHALL return state to IDLE on the next edge regardless of state, including mid-SPI or mid-UART.
REQ-030 Reset values: all strobes 0, busy 0, ss 0, SPI_data 0, ram_addr 0, ram_ch 0, count 0.

Structure
REQ-031 State enum, EEPROM SS code and SPI read-command prefix SHALL live in the shared package.
REQ-032 The DEPTH-modulo address/sample counter SHALL be a sub-module dump_addr_cnt (load, inc, wrap, last flag).

Verification
REQ-033 dump=1, dump_ch=01, ch2_AFEgain=3'b101 -> SPI_data 16'h1A00 then 16'h1B00, ss=100, flopOffset then flopGain on SPI_done.
REQ-034 trig_addr=9'h1FF -> 512 send_resp, ram_addr sequence 0..511, dump_done after 512th resp_sent.
REQ-035 trig_addr=9'h005 -> first ram_addr 6, wraps 511->0, last ram_addr 5.
REQ-036 dump_ch=11 -> dump_err pulse, no wrt_SPI/ram_rd/send_resp, busy stays 0.
REQ-037 rst asserted in WT_TX at sample 100 -> IDLE, busy 0, all outputs at reset values next cycle; new dump restarts from RD_OFF.
REQ-038 dump pulsed during WT_GAIN and SEND -> ignored, sample count still 512.
